// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared constants, event type and parser states for the PS/2 key tracker
package ps2_pkg;

    localparam logic [7:0] PS2_EXT  = 8'hE0;
    localparam logic [7:0] PS2_BRK  = 8'hF0;
    localparam logic [7:0] PS2_ERR0 = 8'h00;
    localparam logic [7:0] PS2_ERR1 = 8'hFF;

    typedef struct packed {
        logic       ext;
        logic       make;
        logic [7:0] code;
    } ps2_evt_t;

    typedef enum logic [1:0] {
        PS_IDLE,
        PS_EXT,
        PS_BRK,
        PS_EXT_BRK
    } ps2_state_t;

endpackage

// File: rtl/ps2_evt_fifo.sv
// rtl/ps2_evt_fifo.sv - first-word-fall-through key event FIFO, no push/pop bypass
module ps2_evt_fifo
    import ps2_pkg::*;
#(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] s_tdata,
    input  logic             s_tvalid,
    output logic             s_tready,
    output logic [WIDTH-1:0] m_tdata,
    output logic             m_tvalid,
    input  logic             m_tready
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [AW:0]      wr_ptr_q, rd_ptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             push, pop;

    // Extra MSB on each pointer separates full from empty when the indices match.
    assign m_tvalid = (wr_ptr_q != rd_ptr_q);
    assign s_tready = !((wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]));
    assign push     = s_tvalid && s_tready;
    assign pop      = m_tvalid && m_tready;
    assign m_tdata  = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= s_tdata;
    end

endmodule

// File: rtl/ps2_key_tracker.sv
// rtl/ps2_key_tracker.sv - scan-code prefix parser and held-key table feeding a key event FIFO
module ps2_key_tracker
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int MAX_HELD   = 4,
    parameter int CNT_W      = 8
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          code_valid,
    input  logic [7:0]                    code,
    output logic                          code_next_n,
    output logic                          ev_valid,
    input  logic                          ev_ready,
    output logic [7:0]                    ev_code,
    output logic                          ev_ext,
    output logic                          ev_make,
    output logic [$clog2(MAX_HELD+1)-1:0] held_cnt,
    output logic                          key_down,
    output logic [CNT_W-1:0]              press_count,
    output logic [7:0]                    last_code,
    output logic                          last_ext,
    output logic                          rollover,
    output logic                          err
);

    localparam int HCW = $clog2(MAX_HELD+1);
    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    ps2_state_t           state_q, state_d;
    logic                 err_q, err_d;
    logic                 rollover_q, rollover_d;
    logic [CNT_W-1:0]     press_q, press_d;
    logic [7:0]           last_code_q, last_code_d;
    logic                 last_ext_q, last_ext_d;
    logic                 popped_q;
    logic [MAX_HELD-1:0]  held_q, held_d;
    logic [8:0]           key_q [MAX_HELD];
    logic [MAX_HELD-1:0]  key_wr;

    logic                 is_err, is_ext, is_brk, is_data;
    logic                 cur_ext, cur_brk, accept, roll_set, free_found;
    logic [8:0]           cur_key;
    logic [MAX_HELD-1:0]  hit_oh, free_oh;
    logic                 evt_push, fifo_ready;
    ps2_evt_t             evt, ev_data;

    function automatic logic [HCW-1:0] popcnt(input logic [MAX_HELD-1:0] v);
        logic [HCW-1:0] n;
        n = '0;
        for (int i = 0; i < MAX_HELD; i++) n = n + HCW'(v[i]);
        return n;
    endfunction

    always_comb begin
        is_err  = (code == PS2_ERR0) || (code == PS2_ERR1);
        is_ext  = (code == PS2_EXT);
        is_brk  = (code == PS2_BRK);
        is_data = !(is_err || is_ext || is_brk);
        cur_ext = (state_q == PS_EXT) || (state_q == PS_EXT_BRK);
        cur_brk = (state_q == PS_BRK) || (state_q == PS_EXT_BRK);
        cur_key = {cur_ext, code};

        hit_oh     = '0;
        free_oh    = '0;
        free_found = 1'b0;
        for (int i = 0; i < MAX_HELD; i++) begin
            hit_oh[i] = held_q[i] && (key_q[i] == cur_key);
            if (!held_q[i] && !free_found) begin
                free_oh[i] = 1'b1;
                free_found = 1'b1;
            end
        end

        // The receiver needs one idle cycle after a pop before its head byte is fresh.
        accept = code_valid && !popped_q && (fifo_ready || !is_data);

        state_d     = state_q;
        err_d       = err_q;
        press_d     = press_q;
        last_code_d = last_code_q;
        last_ext_d  = last_ext_q;
        held_d      = held_q;
        key_wr      = '0;
        roll_set    = 1'b0;
        evt_push    = 1'b0;
        evt.ext     = cur_ext;
        evt.make    = !cur_brk;
        evt.code    = code;

        if (accept) begin
            if (is_err) begin
                err_d   = 1'b1;
                state_d = PS_IDLE;
            end else if (is_ext) begin
                case (state_q)
                    PS_IDLE, PS_EXT: state_d = PS_EXT;
                    default: begin
                        err_d   = 1'b1;
                        state_d = PS_IDLE;
                    end
                endcase
            end else if (is_brk) begin
                case (state_q)
                    PS_IDLE: state_d = PS_BRK;
                    PS_EXT:  state_d = PS_EXT_BRK;
                    PS_BRK:  state_d = PS_BRK;
                    default: begin
                        err_d   = 1'b1;
                        state_d = PS_IDLE;
                    end
                endcase
            end else begin
                state_d = PS_IDLE;
                if (cur_brk) begin
                    evt_push = 1'b1;
                    held_d   = held_q & ~hit_oh;
                end else if (hit_oh == '0) begin
                    // A make for a key already held is typematic repeat and is dropped.
                    evt_push    = 1'b1;
                    press_d     = press_q + CNT_ONE;
                    last_code_d = code;
                    last_ext_d  = cur_ext;
                    if (free_found) begin
                        held_d = held_q | free_oh;
                        key_wr = free_oh;
                    end else begin
                        roll_set = 1'b1;
                    end
                end
            end
        end

        rollover_d = (popcnt(held_d) == '0) ? 1'b0 : (rollover_q || roll_set);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= PS_IDLE;
            err_q       <= 1'b0;
            rollover_q  <= 1'b0;
            press_q     <= '0;
            last_code_q <= '0;
            last_ext_q  <= 1'b0;
            popped_q    <= 1'b0;
            held_q      <= '0;
            for (int i = 0; i < MAX_HELD; i++) key_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            err_q       <= err_d;
            rollover_q  <= rollover_d;
            press_q     <= press_d;
            last_code_q <= last_code_d;
            last_ext_q  <= last_ext_d;
            popped_q    <= accept;
            held_q      <= held_d;
            for (int i = 0; i < MAX_HELD; i++) begin
                if (key_wr[i]) key_q[i] <= cur_key;
            end
        end
    end

    ps2_evt_fifo #(
        .WIDTH ($bits(ps2_evt_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_evt_fifo (
        .clk      (clk),
        .rstn     (rstn),
        .s_tdata  (evt),
        .s_tvalid (evt_push),
        .s_tready (fifo_ready),
        .m_tdata  (ev_data),
        .m_tvalid (ev_valid),
        .m_tready (ev_ready)
    );

    assign code_next_n = !accept;
    assign ev_code     = ev_data.code;
    assign ev_ext      = ev_data.ext;
    assign ev_make     = ev_data.make;
    assign held_cnt    = popcnt(held_q);
    assign key_down    = |held_q;
    assign press_count = press_q;
    assign last_code   = last_code_q;
    assign last_ext    = last_ext_q;
    assign rollover    = rollover_q;
    assign err         = err_q;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// tb/tb_ps2_key_tracker.sv - directed self-checking bench for ps2_key_tracker
module tb_ps2_key_tracker;

    logic       clk;
    logic       rstn;
    logic       code_valid;
    logic [7:0] code;
    logic       code_next_n;
    logic       ev_valid;
    logic       ev_ready;
    logic [7:0] ev_code;
    logic       ev_ext;
    logic       ev_make;
    logic [2:0] held_cnt;
    logic       key_down;
    logic [7:0] press_count;
    logic [7:0] last_code;
    logic       last_ext;
    logic       rollover;
    logic       err;

    int checks = 0;
    int errors = 0;
    int pops, b2b, maxheld;
    logic prev_pop;
    logic [7:0] rxq[$];
    logic [9:0] evq[$];

    ps2_key_tracker #(.FIFO_DEPTH(4), .MAX_HELD(4), .CNT_W(8)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .code_valid  (code_valid),
        .code        (code),
        .code_next_n (code_next_n),
        .ev_valid    (ev_valid),
        .ev_ready    (ev_ready),
        .ev_code     (ev_code),
        .ev_ext      (ev_ext),
        .ev_make     (ev_make),
        .held_cnt    (held_cnt),
        .key_down    (key_down),
        .press_count (press_count),
        .last_code   (last_code),
        .last_ext    (last_ext),
        .rollover    (rollover),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ev_at(input int i);
        if (i < evq.size()) return {22'd0, evq[i]};
        return 32'hDEAD;
    endfunction

    // One cycle of receiver model plus consumer, starting and ending at a negedge.
    task automatic step();
        logic pop_now;
        code_valid = (rxq.size() != 0);
        code       = code_valid ? rxq[0] : 8'h00;
        #1;
        pop_now = !code_next_n;
        if (pop_now) begin
            pops++;
            if (prev_pop) b2b++;
        end
        prev_pop = pop_now;
        if ({29'd0, held_cnt} > maxheld) maxheld = int'(held_cnt);
        if (ev_valid && ev_ready) evq.push_back({ev_ext, ev_make, ev_code});
        @(posedge clk);
        if (pop_now) void'(rxq.pop_front());
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic clear_bench();
        rxq.delete();
        evq.delete();
        pops = 0;
        b2b = 0;
        maxheld = 0;
        prev_pop = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0;
        code_valid = 1'b0;
        code = 8'h00;
        clear_bench();
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic chk_reset_vals(input string p);
        chk({p, "_code_next_n"}, {31'd0, code_next_n}, 1);
        chk({p, "_ev_valid"}, {31'd0, ev_valid}, 0);
        chk({p, "_held_cnt"}, {29'd0, held_cnt}, 0);
        chk({p, "_key_down"}, {31'd0, key_down}, 0);
        chk({p, "_press_count"}, {24'd0, press_count}, 0);
        chk({p, "_last_code"}, {24'd0, last_code}, 0);
        chk({p, "_last_ext"}, {31'd0, last_ext}, 0);
        chk({p, "_rollover"}, {31'd0, rollover}, 0);
        chk({p, "_err"}, {31'd0, err}, 0);
    endtask

    initial begin
        rstn = 1'b0;
        code_valid = 1'b0;
        code = 8'h00;
        ev_ready = 1'b1;
        clear_bench();
        #12;
        chk_reset_vals("rst");

        // make then break of 1C
        do_reset();
        rxq = '{8'h1C, 8'hF0, 8'h1C};
        run(10);
        chk("t1_nev", evq.size(), 2);
        chk("t1_ev0", ev_at(0), 10'h11C);
        chk("t1_ev1", ev_at(1), 10'h01C);
        chk("t1_press", {24'd0, press_count}, 1);
        chk("t1_maxheld", maxheld, 1);
        chk("t1_held", {29'd0, held_cnt}, 0);
        chk("t1_pops", pops, 3);
        chk("t1_b2b", b2b, 0);

        // typematic repeats suppressed
        do_reset();
        rxq = '{8'h1C, 8'h1C, 8'h1C, 8'hF0, 8'h1C};
        run(14);
        chk("t2_nev", evq.size(), 2);
        chk("t2_ev0", ev_at(0), 10'h11C);
        chk("t2_ev1", ev_at(1), 10'h01C);
        chk("t2_press", {24'd0, press_count}, 1);
        chk("t2_last_code", {24'd0, last_code}, 8'h1C);

        // extended key make/break
        do_reset();
        rxq = '{8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75};
        run(14);
        chk("t3_nev", evq.size(), 2);
        chk("t3_ev0", ev_at(0), 10'h375);
        chk("t3_ev1", ev_at(1), 10'h275);
        chk("t3_last_ext", {31'd0, last_ext}, 1);
        chk("t3_last_code", {24'd0, last_code}, 8'h75);
        chk("t3_err", {31'd0, err}, 0);

        // rollover beyond four held keys, then release all
        do_reset();
        rxq = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C};
        run(14);
        chk("t4_nev", evq.size(), 5);
        chk("t4_ev4", ev_at(4), 10'h12C);
        chk("t4_held", {29'd0, held_cnt}, 4);
        chk("t4_rollover", {31'd0, rollover}, 1);
        chk("t4_press", {24'd0, press_count}, 5);
        rxq = '{8'hF0, 8'h15, 8'hF0, 8'h1D, 8'hF0, 8'h24, 8'hF0, 8'h2D, 8'hF0, 8'h2C};
        run(26);
        chk("t4_nev_all", evq.size(), 10);
        chk("t4_ev5", ev_at(5), 10'h015);
        chk("t4_ev9", ev_at(9), 10'h02C);
        chk("t4_held_end", {29'd0, held_cnt}, 0);
        chk("t4_key_down", {31'd0, key_down}, 0);
        chk("t4_rollover_end", {31'd0, rollover}, 0);

        // backpressure with a full event FIFO
        do_reset();
        ev_ready = 1'b0;
        rxq = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h1C};
        run(20);
        chk("t5_pops_stalled", pops, 4);
        chk("t5_ev_valid", {31'd0, ev_valid}, 1);
        chk("t5_rx_left", rxq.size(), 2);
        chk("t5_rx_head", (rxq.size() != 0) ? {24'd0, rxq[0]} : 32'hDEAD, 8'h2C);
        chk("t5_nev_stalled", evq.size(), 0);
        ev_ready = 1'b1;
        run(30);
        chk("t5_pops_all", pops, 6);
        chk("t5_nev", evq.size(), 6);
        chk("t5_ev0", ev_at(0), 10'h115);
        chk("t5_ev1", ev_at(1), 10'h11D);
        chk("t5_ev2", ev_at(2), 10'h124);
        chk("t5_ev3", ev_at(3), 10'h12D);
        chk("t5_ev4", ev_at(4), 10'h12C);
        chk("t5_ev5", ev_at(5), 10'h11C);
        chk("t5_b2b", b2b, 0);
        chk("t5_rollover", {31'd0, rollover}, 1);

        // break followed by E0 is a protocol error
        do_reset();
        rxq = '{8'hF0, 8'hE0, 8'h1C};
        run(10);
        chk("t6_err", {31'd0, err}, 1);
        chk("t6_nev", evq.size(), 1);
        chk("t6_ev0", ev_at(0), 10'h11C);
        chk("t6_held", {29'd0, held_cnt}, 1);
        rxq = '{8'h00};
        run(4);
        chk("t6_err_sticky", {31'd0, err}, 1);
        chk("t6_held_kept", {29'd0, held_cnt}, 1);

        // reset mid-sequence drops prefix and queued events
        do_reset();
        ev_ready = 1'b0;
        rxq = '{8'h1C, 8'hE0};
        run(6);
        chk("t7_ev_valid_pre", {31'd0, ev_valid}, 1);
        chk("t7_press_pre", {24'd0, press_count}, 1);
        @(negedge clk);
        rstn = 1'b0;
        code_valid = 1'b0;
        #2;
        chk_reset_vals("t7_rst");
        @(negedge clk);
        rstn = 1'b1;
        clear_bench();
        ev_ready = 1'b1;
        rxq = '{8'h1C};
        run(6);
        chk("t7_nev", evq.size(), 1);
        chk("t7_ev0", ev_at(0), 10'h11C);
        chk("t7_last_ext", {31'd0, last_ext}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ps2_key_tracker.md
Name: ps2_key_tracker

Overview:
Parametrised successor to the single-key code analysis stage of the PS/2 keyboard path. Sits between the PS/2 receiver byte FIFO and the display/consumer logic. Pops scan-code bytes under handshake, parses E0 (extended) and F0 (break) prefixes, and tracks up to MAX_HELD simultaneously held keys with typematic-repeat suppression. Emits key events through an internal event FIFO with valid/ready backpressure.

Parameters:
FIFO_DEPTH, 4, event FIFO depth; power of two, >= 2
MAX_HELD, 4, held-key table entries, >= 1
CNT_W, 8, width of press counter

Ports:
clk  in  1  system clock
rstn  in  1  asynchronous active-low reset
code_valid  in  1  receiver has a byte (receiver "ready")
code  in  8  receiver head byte
code_next_n  out  1  active-low pop, one-cycle pulse per consumed byte
ev_valid  out  1  event FIFO non-empty
ev_ready  in  1  consumer takes event when ev_valid && ev_ready
ev_code  out  8  event scan code (prefixes stripped)
ev_ext  out  1  event had E0 prefix
ev_make  out  1  1 = press, 0 = release
held_cnt  out  $clog2(MAX_HELD+1)  keys currently held
key_down  out  1  held_cnt != 0
press_count  out  CNT_W  new presses since reset, wraps modulo 2^CNT_W
last_code  out  8  code of most recent new press
last_ext  out  1  ext flag of most recent new press
rollover  out  1  a press could not be tracked; cleared when held_cnt reaches 0
err  out  1  sticky protocol error, cleared only by reset

Behaviour:
- Reset: code_next_n=1, ev_valid=0, held table empty, held_cnt=0, key_down=0, press_count=0, last_code=0, last_ext=0, rollover=0, err=0, parser in IDLE. Reset mid-sequence discards any partial prefix and all queued events.
- Byte acceptance in cycle t requires all of: code_valid=1; no pop issued in t-1 (receiver head update gap); and either event FIFO not full or byte is a prefix/error byte. On acceptance, code_next_n=0 in cycle t only.
- Full FIFO stalls acceptance of code bytes even if ev_ready=1 in the same cycle. No push/pop bypass.
- Parser states: IDLE, EXT, BRK, EXT_BRK.
  IDLE: E0->EXT; F0->BRK; code->make(ext=0).
  EXT: F0->EXT_BRK; E0->EXT (repeat tolerated); code->make(ext=1).
  BRK: F0->BRK; E0->err=1, IDLE; code->break(ext=0).
  EXT_BRK: E0 or F0->err=1, IDLE; code->break(ext=1).
  Bytes 00 or FF in any state: err=1, byte discarded, state->IDLE.
  After every make/break the parser returns to IDLE.
- Make with {ext,code} already held: typematic repeat. No event, no count, no table change.
- New make:
  - Push event {ext,code,1}; press_count+1; last_code/last_ext updated.
  - Insert into the lowest free table slot.
  - If the table is full: rollover=1, event still pushed, key not tracked.
- Break:
  - Push event {ext,code,0}.
  - If {ext,code} is held, free its slot. If not held, the event is still pushed and the table is unchanged.
- rollover clears in the cycle held_cnt becomes 0.
- Latency: byte accepted at t gives ev_valid at t+1 (FIFO was empty) and updated held_cnt/press_count at t+1.
- Event FIFO is first-word-fall-through, in order. Pointers wrap modulo FIFO_DEPTH; full/empty distinguished by an extra pointer bit.

Decomposition:
- Package ps2_pkg:
  - PS2_EXT=8'hE0, PS2_BRK=8'hF0, PS2_ERR0=8'h00, PS2_ERR1=8'hFF.
  - Typedef ps2_evt_t {ext, make, code[7:0]} (10 bits).
  - Parser state enum.
- One sub-module: ps2_evt_fifo, a parametrised synchronous FWFT FIFO (width 10, depth FIFO_DEPTH) with the same clk/rstn.
- Parser and held table live in ps2_key_tracker.

Test Plan:
- Bytes 1C, F0, 1C with ev_ready=1:
  - Events {0,1,1C} then {0,0,1C}.
  - press_count=1; held_cnt goes 1 then 0; code_next_n low exactly 3 single cycles, never back-to-back.
- Bytes 1C, 1C, 1C, F0, 1C:
  - One make event and one break event only.
  - press_count=1, last_code=1C.
- Bytes E0, 75, E0, F0, 75:
  - Events {1,1,75} then {1,0,75}.
  - last_ext=1, err=0.
- MAX_HELD=4, makes 15,1D,24,2D,2C:
  - 5 make events, held_cnt=4, rollover=1.
  - Breaks for all five: held_cnt=0, rollover=0.
- FIFO_DEPTH=4, ev_ready=0, six distinct makes queued in the receiver:
  - Exactly 4 pops, ev_valid=1, fifth byte left unconsumed.
  - Raise ev_ready: remaining bytes consumed, events delivered in order.
- Error and reset cases:
  - F0, E0 -> err=1, parser IDLE; a following 1C gives make {0,1,1C}.
  - rstn low after a lone E0 -> all outputs return to reset values; next 1C gives ext=0.
